// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: word layout, column-major state view and
// the row-rotation helpers used by the ShiftRows / InvShiftRows stages.
package aes_pkg;

    localparam int HDR_W   = 4;
    localparam int STATE_W = 128;
    localparam int WORD_W  = HDR_W + STATE_W;

    // Indexed [column][row][bit]; byte p sits at column p/4, row p%4.
    typedef logic [3:0][3:0][7:0] state_t;

    function automatic state_t to_state(input logic [STATE_W-1:0] bits);
        state_t s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[c][r] = bits[(4*c + r)*8 +: 8];
            end
        end
        return s;
    endfunction

    function automatic logic [STATE_W-1:0] from_state(input state_t s);
        logic [STATE_W-1:0] bits;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                bits[(4*c + r)*8 +: 8] = s[c][r];
            end
        end
        return bits;
    endfunction

    // Row 3 is the unrotated row; rows 0..2 rotate by 1..3 columns.
    function automatic logic [1:0] row_rot(input int r);
        return 2'((r + 1) % 4);
    endfunction

    // Source column feeding out[r][c] on the decrypt side.
    function automatic logic [1:0] inv_src_col(input int c, input int r);
        return 2'(c) + row_rot(r);
    endfunction

    // Source column feeding out[r][c] on the encrypt side.
    function automatic logic [1:0] fwd_src_col(input int c, input int r);
        return 2'(c) - row_rot(r);
    endfunction

endpackage

// File: rtl/inv_shift_rows_comb.sv
// Pure InvShiftRows byte permutation on a header+state word; the header
// passes through untouched.
module inv_shift_rows_comb
    import aes_pkg::*;
#(
    parameter int HDR_W = 4
) (
    input  logic [HDR_W+STATE_W-1:0] word_in,
    output logic [HDR_W+STATE_W-1:0] word_out
);

    state_t state_in;
    state_t state_out;

    assign state_in = to_state(word_in[STATE_W-1:0]);

    always_comb begin
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                state_out[c][r] = state_in[inv_src_col(c, r)][r];
            end
        end
    end

    assign word_out[STATE_W-1:0]             = from_state(state_out);
    assign word_out[HDR_W+STATE_W-1:STATE_W] = word_in[HDR_W+STATE_W-1:STATE_W];

endmodule

// File: rtl/inv_shift_rows_stage.sv
// Decrypt-path InvShiftRows stage: permutes the incoming word and buffers the
// result in a small valid/ready FIFO so the decrypt pipeline can stall.
module inv_shift_rows_stage
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int HDR_W = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [HDR_W+STATE_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HDR_W+STATE_W-1:0] out_data,
    output logic [CNT_W-1:0]         occupancy
);

    localparam int W     = HDR_W + STATE_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     shifted_p0;
    logic [W-1:0]     mem_p1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    inv_shift_rows_comb #(
        .HDR_W (HDR_W)
    ) u_perm (
        .word_in  (in_data),
        .word_out (shifted_p0)
    );

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_ready  = (count < CNT_W'(DEPTH)) | out_ready;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // ---- stage p0 -> p1: capture permuted word, advance pointers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_p1[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem_p1[wr_ptr] <= shifted_p0;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_data  = out_valid ? mem_p1[rd_ptr] : '0;
    assign occupancy = count;

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Directed bench for inv_shift_rows_stage with a byte-level reference model
// and a queue scoreboard checked every cycle.
module tb_inv_shift_rows_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef logic [131:0] word_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    word_t        in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    word_t        out_data;
    logic [CNT_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    word_t exp_q[$];

    inv_shift_rows_stage #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Row r of the state is rotated left by this many columns on decrypt.
    function automatic int shift_of(int r);
        return (r == 3) ? 0 : r + 1;
    endfunction

    function automatic word_t inv_model(word_t w);
        logic [7:0] b [16];
        word_t o;
        for (int p = 0; p < 16; p++) b[p] = w[8*p +: 8];
        o = w;
        for (int p = 0; p < 16; p++) begin
            int r, c;
            r = p % 4;
            c = p / 4;
            o[8*p +: 8] = b[4*((c + shift_of(r)) % 4) + r];
        end
        return o;
    endfunction

    function automatic word_t enc_model(word_t w);
        logic [7:0] b [16];
        word_t o;
        for (int p = 0; p < 16; p++) b[p] = w[8*p +: 8];
        o = w;
        for (int p = 0; p < 16; p++) begin
            int r, c;
            r = p % 4;
            c = p / 4;
            o[8*p +: 8] = b[4*((c + 4 - shift_of(r)) % 4) + r];
        end
        return o;
    endfunction

    function automatic word_t rand_word();
        return {4'($urandom), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: updates the expected FIFO contents at each edge.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
            end else if (flush) begin
                exp_q.delete();
            end else begin
                bit m_rdy, m_push, m_pop;
                m_rdy  = (exp_q.size() < DEPTH) || out_ready;
                m_push = in_valid && m_rdy;
                m_pop  = (exp_q.size() != 0) && out_ready;
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) exp_q.push_back(inv_model(in_data));
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", word_t'(out_valid), word_t'(exp_q.size() != 0));
            chk("occupancy", word_t'(occupancy), word_t'(exp_q.size()));
            chk("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
            if (!flush)
                chk("in_ready", word_t'(in_ready),
                    word_t'((exp_q.size() < DEPTH) || out_ready));
        end
    end

    initial begin
        word_t w, prev, perm_in, perm_exp;
        word_t bp [3];

        // Reset values
        @(negedge clk);
        chk("rst_out_valid", word_t'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_occupancy", word_t'(occupancy), '0);
        chk("rst_in_ready", word_t'(in_ready), 132'd1);
        step();
        rst = 1'b0;

        // Permutation of byte p = p with header 0xA
        perm_in  = 132'hA_0F0E0D0C_0B0A0908_07060504_03020100;
        perm_exp = 132'hA_0F0A0500_0B06010C_07020D08_030E0904;
        chk("model_perm", inv_model(perm_in), perm_exp);
        chk("model_roundtrip", inv_model(enc_model(perm_in)), perm_in);
        step();
        in_valid = 1'b1;
        in_data  = perm_in;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("perm_out", out_data, perm_exp);
        chk("perm_byte4", word_t'(out_data[39:32]), 132'h08);
        chk("perm_hdr", word_t'(out_data[131:128]), 132'hA);
        step();
        out_ready = 1'b1;
        step();

        // Round trip through encrypt model then DUT, one-cycle latency
        prev = '0;
        for (int i = 0; i < 1000; i++) begin
            w = rand_word();
            in_valid = 1'b1;
            in_data  = enc_model(w);
            @(negedge clk);
            if (i > 0) chk("roundtrip", out_data, prev);
            prev = w;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("roundtrip_last", out_data, prev);
        step();
        step();

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) bp[i] = rand_word();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = bp[i];
            step();
        end
        @(negedge clk);
        chk("bp_occupancy", word_t'(occupancy), 132'd2);
        chk("bp_in_ready", word_t'(in_ready), '0);
        chk("bp_head", out_data, inv_model(bp[0]));
        step();
        out_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", word_t'(in_ready), 132'd1);
        step();
        in_valid = 1'b0;
        chk("bp_second", out_data, inv_model(bp[1]));
        step();
        chk("bp_third", out_data, inv_model(bp[2]));
        step();
        step();

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = rand_word();
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = rand_word();
            @(negedge clk);
            chk("full_pp_occ", word_t'(occupancy), 132'd2);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        step();

        // Flush with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = rand_word();
            step();
        end
        flush   = 1'b1;
        in_data = rand_word();
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", word_t'(occupancy), '0);
        chk("flush_valid", word_t'(out_valid), '0);
        step();
        chk("flush_no_store", word_t'(out_valid), '0);

        // Asynchronous reset between edges
        in_valid = 1'b1;
        in_data  = rand_word();
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_occ", word_t'(occupancy), 132'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", word_t'(out_valid), '0);
        chk("async_rst_occ", word_t'(occupancy), '0);
        chk("async_rst_data", out_data, '0);
        step();
        #2;
        rst = 1'b0;
        step();
        w = rand_word();
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        chk("post_rst_word", out_data, inv_model(w));
        out_ready = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
